// File: rtl/arb2_sync.sv
// Two-party break-before-make lock arbiter with round-robin tie-break.
// Optional grant timeout compiled in with `define ARB2_TIMEOUT_EN (limit = HOLD_MAX cycles).
module arb2_sync #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req_a,
  input  logic       i_req_b,
  output logic [1:0] o_gnt,
  output logic       o_last,
  output logic       o_tout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GNT_A = 2'd1,
    S_GNT_B = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  if ((HOLD_MAX < 2) || (HOLD_MAX > 65535)) begin : g_hold_max_range
    $error("arb2_sync: HOLD_MAX must be in 2..65535");
  end

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_gnt;
  logic       r_last;
  logic [1:0] w_need_drop;  // [1] = A, [0] = B
  logic       w_tmo_a;
  logic       w_tmo_b;
  logic       w_elig_a;
  logic       w_elig_b;

  assign w_elig_a = i_req_a & ~w_need_drop[1];
  assign w_elig_b = i_req_b & ~w_need_drop[0];

`ifdef ARB2_TIMEOUT_EN
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_MAX - 1);

  logic [15:0] r_hold_cnt;
  logic [1:0]  r_need_drop;
  logic        r_tout;

  assign w_tmo_a     = (r_state == S_GNT_A) && i_req_a && (r_hold_cnt == HOLD_LAST);
  assign w_tmo_b     = (r_state == S_GNT_B) && i_req_b && (r_hold_cnt == HOLD_LAST);
  assign w_need_drop = r_need_drop;
  assign o_tout      = r_tout;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold_cnt  <= 16'd0;
      r_need_drop <= 2'b00;
      r_tout      <= 1'b0;
    end else begin
      r_tout <= w_tmo_a | w_tmo_b;
      if (((w_next == S_GNT_A) || (w_next == S_GNT_B)) && (w_next != r_state)) begin
        r_hold_cnt <= 16'd0;
      end else if ((r_state == S_GNT_A) || (r_state == S_GNT_B)) begin
        r_hold_cnt <= r_hold_cnt + 16'd1;
      end
      // A revoked side must be seen idle once before it is eligible again.
      if (w_tmo_a)       r_need_drop[1] <= 1'b1;
      else if (!i_req_a) r_need_drop[1] <= 1'b0;
      if (w_tmo_b)       r_need_drop[0] <= 1'b1;
      else if (!i_req_b) r_need_drop[0] <= 1'b0;
    end
  end
`else
  assign w_tmo_a     = 1'b0;
  assign w_tmo_b     = 1'b0;
  assign w_need_drop = 2'b00;
  assign o_tout      = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_GAP: begin
        if (w_elig_a && w_elig_b) w_next = r_last ? S_GNT_A : S_GNT_B;
        else if (w_elig_a)        w_next = S_GNT_A;
        else if (w_elig_b)        w_next = S_GNT_B;
        else                      w_next = S_IDLE;
      end
      S_GNT_A: if (!i_req_a || w_tmo_a) w_next = S_GAP;
      S_GNT_B: if (!i_req_b || w_tmo_b) w_next = S_GAP;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_gnt   <= 2'b00;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      r_gnt   <= {w_next == S_GNT_A, w_next == S_GNT_B};
      if ((w_next == S_GNT_A) && (r_state != S_GNT_A))      r_last <= 1'b0;
      else if ((w_next == S_GNT_B) && (r_state != S_GNT_B)) r_last <= 1'b1;
    end
  end

  assign o_gnt  = r_gnt;
  assign o_last = r_last;

endmodule

// File: tb/tb_arb2_sync.sv
// Self-checking bench for arb2_sync: ownership model + directed vectors + random soak.
module tb_arb2_sync;

  localparam int HOLD = 4;
`ifdef ARB2_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a = 1'b0;
  logic       req_b = 1'b0;
  logic [1:0] gnt;
  logic       last;
  logic       tout;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  arb2_sync #(.HOLD_MAX(HOLD)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_req_a(req_a),
    .i_req_b(req_b),
    .o_gnt  (gnt),
    .o_last (last),
    .o_tout (tout)
  );

  always #5 clk = ~clk;

  // Model: who owns the lock (0 none, 1 A, 2 B) and how many cycles it has held it.
  int owner  = 0;
  int held   = 0;
  bit m_last = 1'b1;
  bit m_tout = 1'b0;
  bit drop_a = 1'b0;
  bit drop_b = 1'b0;

  function automatic logic [1:0] m_gnt();
    return (owner == 1) ? 2'b10 : (owner == 2) ? 2'b01 : 2'b00;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      owner = 0; held = 0; m_last = 1'b1; m_tout = 1'b0; drop_a = 1'b0; drop_b = 1'b0;
    end else begin
      bit ea, eb, own_req;
      ea = req_a && !drop_a;
      eb = req_b && !drop_b;
      m_tout = 1'b0;
      if (owner != 0) begin
        own_req = (owner == 1) ? req_a : req_b;
        if (!own_req) begin
          owner = 0;
        end else if (TMO_EN && held == HOLD) begin
          if (owner == 1) drop_a = 1'b1; else drop_b = 1'b1;
          owner  = 0;
          m_tout = 1'b1;
        end else begin
          held++;
        end
      end else if (ea || eb) begin
        if (ea && eb) owner = m_last ? 1 : 2;
        else          owner = ea ? 1 : 2;
        m_last = (owner == 2);
        held   = 1;
      end
      if (!req_a) drop_a = 1'b0;
      if (!req_b) drop_b = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  logic [1:0] prev_gnt = 2'b00;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("gnt", gnt, m_gnt());
      chk("last", {1'b0, last}, {1'b0, m_last});
      chk("tout", {1'b0, tout}, {1'b0, m_tout});
      chk("gnt_not_11", {1'b0, gnt == 2'b11}, 2'b00);
      chk("break_before_make",
          {1'b0, (prev_gnt != 2'b00) && (gnt != 2'b00) && (gnt != prev_gnt)}, 2'b00);
      prev_gnt = gnt;
    end
  end

  task automatic cyc(input logic ra, input logic rb, input logic rs);
    req_a = ra; req_b = rb; rst = rs;
    @(posedge clk);
    #2;
  endtask

  // Literal expectation checked against both the DUT and the model.
  task automatic lit(input string name, input logic [1:0] exp_gnt, input logic exp_last);
    chk({name, "_gnt"}, gnt, exp_gnt);
    chk({name, "_last"}, {1'b0, last}, {1'b0, exp_last});
    chk({name, "_model_gnt"}, m_gnt(), exp_gnt);
  endtask

  initial begin
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    chk_en = 1'b1;
    lit("reset", 2'b00, 1'b1);
    chk("reset_tout", {1'b0, tout}, 2'b00);

    // Single requester grant and release
    cyc(1, 0, 0); lit("a_grant", 2'b10, 1'b0);
    cyc(1, 0, 0); cyc(1, 0, 0);
    cyc(0, 0, 0); lit("a_release", 2'b00, 1'b0);
    cyc(0, 0, 0); lit("a_idle", 2'b00, 1'b0);

    // Tie after reset, handover through a gap, round-robin back
    cyc(0, 0, 1);
    cyc(1, 1, 0); lit("tie_a", 2'b10, 1'b0);
    cyc(0, 1, 0); lit("tie_gap", 2'b00, 1'b0);
    cyc(1, 1, 0); lit("rr_b", 2'b01, 1'b1);
    cyc(1, 0, 0); lit("rr_gap", 2'b00, 1'b1);
    cyc(1, 1, 0); lit("rr_a", 2'b10, 1'b0);
    cyc(0, 0, 0); cyc(0, 0, 0);

    // Other side ignored while B holds
    cyc(0, 0, 1);
    cyc(0, 1, 0); lit("b_hold", 2'b01, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0); lit("b_hold_a_pulse", 2'b01, 1'b1);
    end
    cyc(0, 0, 0); lit("b_release", 2'b00, 1'b1);
    cyc(0, 0, 0); lit("a_never", 2'b00, 1'b1);

    // Reset mid-grant
    cyc(0, 1, 0); lit("pre_rst_b", 2'b01, 1'b1);
    cyc(0, 1, 1); lit("mid_rst", 2'b00, 1'b1);
    cyc(1, 1, 0); lit("post_rst_tie", 2'b10, 1'b0);
    cyc(0, 0, 0); cyc(0, 0, 0);

    if (TMO_EN) begin
      cyc(0, 0, 1);
      cyc(1, 0, 0); lit("tmo_a1", 2'b10, 1'b0);
      for (int i = 0; i < 3; i++) begin
        cyc(1, 0, 0); lit("tmo_a_hold", 2'b10, 1'b0);
      end
      cyc(1, 1, 0); lit("tmo_revoke", 2'b00, 1'b0);
      chk("tmo_pulse", {1'b0, tout}, 2'b01);
      cyc(1, 1, 0); lit("tmo_b_after", 2'b01, 1'b1);
      chk("tmo_pulse_end", {1'b0, tout}, 2'b00);
      cyc(1, 0, 0); lit("tmo_b_rel", 2'b00, 1'b1);
      cyc(1, 0, 0); lit("tmo_a_blocked", 2'b00, 1'b1);
      cyc(0, 0, 0); lit("tmo_a_low", 2'b00, 1'b1);
      cyc(1, 0, 0); lit("tmo_a_regrant", 2'b10, 1'b0);
      cyc(0, 0, 0); cyc(0, 0, 0);
    end else begin
      cyc(1, 0, 0);
      for (int i = 0; i < 20; i++) cyc(1, 1, 0);
      lit("no_tmo_long_hold", 2'b10, 1'b0);
      chk("no_tmo_tout", {1'b0, tout}, 2'b00);
      cyc(0, 0, 0); cyc(0, 0, 0);
    end

    // Random soak
    for (int i = 0; i < 10000; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 199) == 0));
    end
    cyc(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
